instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter in the multi-cycle RISC-V core. It takes the current PC and issues one word request at a time to instruction memory over a valid/ready handshake. It captures the returned instruction with its PC in a single-entry IF buffer for decode, and pulses the PC register's write enable when a fetch completes. A redirect (taken branch/jump) flushes the buffer and discards any in-flight response.

---
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Single-outstanding instruction fetch with a one-entry IF buffer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_fetch_unit #(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        misalign_fault
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_FULL  = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;

  localparam int               c_CNT_W     = (RESET_IDLE_CYCLES > 1) ? $clog2(RESET_IDLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_IDLE_LAST = c_CNT_W'(RESET_IDLE_CYCLES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_idle_cnt;
  logic [31:0]        r_pend_pc;
  logic               r_if_valid;
  logic [31:0]        r_if_instr;
  logic [31:0]        r_if_pc;
  logic               w_aligned;
  logic               w_req_hs;

  assign w_aligned      = (pc_in[1:0] == 2'b00);
  assign imem_req_valid = (r_state == c_REQ) && w_aligned && !flush;
  assign imem_req_addr  = (r_state == c_REQ) ? pc_in : 32'd0;
  assign misalign_fault = (r_state == c_REQ) && !w_aligned;
  assign w_req_hs       = imem_req_valid && imem_req_ready;
  assign pc_advance     = (r_state == c_WAIT) && imem_resp_valid && !flush;

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (r_idle_cnt == c_IDLE_LAST) w_state_nxt = c_REQ;
      // req_valid is masked by flush, so a flush in REQ can never carry an acceptance
      c_REQ:   if (w_req_hs) w_state_nxt = c_WAIT;
      c_WAIT: begin
        if (flush)                w_state_nxt = imem_resp_valid ? c_REQ : c_DRAIN;
        else if (imem_resp_valid) w_state_nxt = c_FULL;
      end
      c_FULL:  if (flush || if_ready) w_state_nxt = c_REQ;
      // flush does not alter draining; the orphaned response is still consumed
      c_DRAIN: if (imem_resp_valid) w_state_nxt = c_REQ;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_idle_cnt <= '0;
      r_pend_pc  <= 32'd0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_IDLE && r_idle_cnt != c_IDLE_LAST)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_req_hs)
        r_pend_pc <= pc_in;
      if (pc_advance) begin
        r_if_valid <= 1'b1;
        r_if_instr <= imem_resp_data;
        r_if_pc    <= r_pend_pc;
      end else if (r_state == c_FULL && (flush || if_ready)) begin
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Directed self-checking bench for instr_fetch_unit.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_advance;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        misalign_fault;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.RESET_IDLE_CYCLES(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .flush           (flush),
    .pc_advance      (pc_advance),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_ready        (if_ready),
    .misalign_fault  (misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the rising edge in between commits state.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = 32'd0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b0;
    step();
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_adv", pc_advance, 0);
    chk("rst_misalign", misalign_fault, 0);
    step();
    #1 chk("rst_hold_req", imem_req_valid, 0);
    step();

    // First fetch, zero-wait memory
    rst = 1'b0; imem_req_ready = 1'b1;
    #1 chk("idle_no_req", imem_req_valid, 0);
    step();
    #1 chk("f0_req_valid", imem_req_valid, 1);
    chk("f0_addr", imem_req_addr, 32'h0);
    chk("f0_no_adv", pc_advance, 0);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    #1 chk("f0_pc_adv", pc_advance, 1);
    chk("f0_wait_no_req", imem_req_valid, 0);
    step();
    imem_resp_valid = 1'b0; pc_in = 32'h4; if_ready = 1'b1;
    #1 chk("f0_if_valid", if_valid, 1);
    chk("f0_if_instr", if_instr, 32'h13);
    chk("f0_if_pc", if_pc, 32'h0);
    chk("f0_full_no_adv", pc_advance, 0);
    step();

    // Back-pressured request, slow response
    if_ready = 1'b0; imem_req_ready = 1'b0;
    #1 chk("bp_req_c0", imem_req_valid, 1);
    chk("bp_addr_c0", imem_req_addr, 32'h4);
    step();
    #1 chk("bp_req_c1", imem_req_valid, 1);
    chk("bp_addr_c1", imem_req_addr, 32'h4);
    step();
    imem_req_ready = 1'b1;
    #1 chk("bp_req_c2", imem_req_valid, 1);
    chk("bp_addr_c2", imem_req_addr, 32'h4);
    step();
    imem_req_ready = 1'b0;
    #1 chk("slow_no_adv0", pc_advance, 0);
    chk("slow_no_req", imem_req_valid, 0);
    step();
    #1 chk("slow_no_adv1", pc_advance, 0);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hAABB_CCDD;
    #1 chk("slow_pc_adv", pc_advance, 1);
    step();

    // Decode stall for four cycles
    imem_resp_valid = 1'b0; pc_in = 32'h8; if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("stall_if_valid", if_valid, 1);
      chk("stall_if_instr", if_instr, 32'hAABB_CCDD);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_no_req", imem_req_valid, 0);
      chk("stall_no_adv", pc_advance, 0);
      step();
    end
    if_ready = 1'b1;
    #1 chk("deq_if_valid", if_valid, 1);
    chk("deq_no_req", imem_req_valid, 0);
    step();

    // Flush in WAIT without response -> DRAIN
    if_ready = 1'b0; pc_in = 32'h100; imem_req_ready = 1'b1;
    #1 chk("deq_cleared", if_valid, 0);
    chk("r100_req", imem_req_valid, 1);
    chk("r100_addr", imem_req_addr, 32'h100);
    step();
    flush = 1'b1;
    #1 chk("wflush_no_adv", pc_advance, 0);
    chk("wflush_no_req", imem_req_valid, 0);
    step();
    flush = 1'b0; pc_in = 32'h200;
    #1 chk("drain_no_req", imem_req_valid, 0);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    #1 chk("drain_no_adv", pc_advance, 0);
    chk("drain_no_req2", imem_req_valid, 0);
    step();
    imem_resp_valid = 1'b0;
    #1 chk("drain_if_valid", if_valid, 0);
    chk("r200_req", imem_req_valid, 1);
    chk("r200_addr", imem_req_addr, 32'h200);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0111;
    #1 chk("r200_adv", pc_advance, 1);
    step();
    imem_resp_valid = 1'b0; pc_in = 32'h204; if_ready = 1'b1;
    #1 chk("r200_if_pc", if_pc, 32'h200);
    chk("r200_if_instr", if_instr, 32'h111);
    step();

    // Fetch at 0x40 then flush while FULL
    if_ready = 1'b0; pc_in = 32'h40;
    #1 chk("r40_req", imem_req_valid, 1);
    chk("r40_addr", imem_req_addr, 32'h40);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0222;
    #1 chk("r40_adv", pc_advance, 1);
    step();
    imem_resp_valid = 1'b0; pc_in = 32'h44; flush = 1'b1;
    #1 chk("ff_if_valid", if_valid, 1);
    chk("ff_if_pc", if_pc, 32'h40);
    chk("ff_no_adv", pc_advance, 0);
    step();
    flush = 1'b0; pc_in = 32'h80; imem_req_ready = 1'b0;
    #1 chk("ff_cleared", if_valid, 0);
    chk("r80_req", imem_req_valid, 1);
    chk("r80_addr", imem_req_addr, 32'h80);
    step();

    // Misaligned PC, recovered by a flush
    pc_in = 32'h102; imem_req_ready = 1'b1;
    #1 chk("mis_fault0", misalign_fault, 1);
    chk("mis_no_req0", imem_req_valid, 0);
    step();
    #1 chk("mis_fault1", misalign_fault, 1);
    chk("mis_no_req1", imem_req_valid, 0);
    step();
    flush = 1'b1;
    #1 chk("mis_flush_no_req", imem_req_valid, 0);
    step();
    flush = 1'b0; pc_in = 32'h104;
    #1 chk("mis_cleared", misalign_fault, 0);
    chk("r104_req", imem_req_valid, 1);
    chk("r104_addr", imem_req_addr, 32'h104);
    step();

    // Reset in the middle of a fetch
    rst = 1'b1;
    #1 chk("mid_rst_no_adv", pc_advance, 0);
    step();
    #1 chk("mid_rst_req", imem_req_valid, 0);
    chk("mid_rst_if_valid", if_valid, 0);
    chk("mid_rst_if_pc", if_pc, 32'h0);
    chk("mid_rst_if_instr", if_instr, 32'h0);
    chk("mid_rst_misalign", misalign_fault, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
